// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module   : mem_port_arbiter_if
// Function : fetch, data and shared-memory bus signals of the port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_load;
  logic        dm_store;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dm_load, dm_store, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_valid, dm_rdata, dm_valid, stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  // Pipeline / memory side
  modport master (
    output if_req, if_addr, dm_load, dm_store, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_valid, dm_rdata, dm_valid, stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Function : shares one single-port memory between instruction fetch and
//            data access, data first with a bounded fetch-starvation window.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_port_arbiter #(
  parameter int IF_STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [3:0] c_starve_max = 4'(IF_STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_grant_if;
  logic        w_grant_dm;
  logic        w_done;
  logic        w_dm_req;
  logic        w_if_first;

  logic [3:0]  r_starve_cnt;
  logic        r_dm_is_load;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;
  logic        r_if_valid;
  logic        r_dm_valid;

  assign w_dm_req   = bus.dm_load | bus.dm_store;
  // Fetch only jumps the queue once data has won IF_STARVE_MAX times in a row
  assign w_if_first = bus.if_req & (~w_dm_req | (r_starve_cnt == c_starve_max));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_dm  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_if_first) begin
          w_grant_if  = 1'b1;
          w_state_nxt = BUSY_IF;
        end else if (w_dm_req) begin
          w_grant_dm  = 1'b1;
          w_state_nxt = BUSY_DM;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (bus.mem_ack) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= 4'd0;
      r_dm_is_load <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'h0000_0000;
      r_mem_wdata  <= 32'h0000_0000;
      r_if_rdata   <= 32'h0000_0000;
      r_dm_rdata   <= 32'h0000_0000;
      r_if_valid   <= 1'b0;
      r_dm_valid   <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      if (w_grant_if) begin
        r_mem_req    <= 1'b1;
        r_mem_we     <= 1'b0;
        r_mem_addr   <= bus.if_addr;
        r_starve_cnt <= 4'd0;
      end
      if (w_grant_dm) begin
        // A simultaneous load and store is serviced as a store
        r_mem_req    <= 1'b1;
        r_mem_we     <= bus.dm_store;
        r_mem_addr   <= bus.dm_addr;
        r_mem_wdata  <= bus.dm_wdata;
        r_dm_is_load <= ~bus.dm_store;
        if (bus.if_req && (r_starve_cnt < c_starve_max))
          r_starve_cnt <= r_starve_cnt + 4'd1;
      end
      if (w_done) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
        if (r_state == BUSY_IF) begin
          r_if_rdata <= bus.mem_rdata;
          r_if_valid <= 1'b1;
        end else begin
          r_dm_valid <= 1'b1;
          if (r_dm_is_load) r_dm_rdata <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_valid  = r_if_valid;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.dm_valid  = r_dm_valid;
  assign bus.stall     = (w_dm_req & ~r_dm_valid) | (bus.if_req & ~r_if_valid);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Function : directed self-checking bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.IF_STARVE_MAX(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_compared   = 0;
  int          n_mismatched = 0;
  int          ack_delay    = 1;
  bit          stray_ack    = 1'b0;
  int          ack_cnt      = 0;
  logic        prev_req     = 1'b0;
  logic [32:0] grant_log[$];

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] addr);
    return (addr == 32'h0040_0000) ? 32'h2008_0005 : ~addr;
  endfunction

  // Memory responder: ack after ack_delay cycles of mem_req
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (stray_ack) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        ack_cnt       = 0;
      end else if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        ack_cnt     = 0;
      end else if (bus.mem_req) begin
        ack_cnt++;
        if (ack_cnt >= ack_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_model(bus.mem_addr);
        end
      end else begin
        ack_cnt = 0;
      end
    end
  end

  // Grant logger: one entry per rising mem_req
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_req && !prev_req) grant_log.push_back({bus.mem_we, bus.mem_addr});
      prev_req = bus.mem_req;
    end
  end

  task automatic wait_valid(input string tag, input bit want_if, output int cycles);
    logic v;
    cycles = 0;
    v      = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cycles++;
      v = want_if ? bus.if_valid : bus.dm_valid;
      if (v) return;
    end
    check_value({tag, " timeout"}, 32'(v), 32'd1);
  endtask

  initial begin
    int          cyc;
    int          busy;
    int          n_valid;
    logic [31:0] exp_order [6];
    exp_order = '{32'h1001_0008, 32'h1001_0008, 32'h0040_0000,
                  32'h1001_0008, 32'h1001_0008, 32'h0040_0000};

    reset        = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'h0;
    bus.dm_load  = 1'b0;
    bus.dm_store = 1'b0;
    bus.dm_addr  = 32'h0;
    bus.dm_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_value("rst mem_req",   32'(bus.mem_req),  32'd0);
    check_value("rst mem_we",    32'(bus.mem_we),   32'd0);
    check_value("rst mem_addr",  bus.mem_addr,      32'h0);
    check_value("rst mem_wdata", bus.mem_wdata,     32'h0);
    check_value("rst if_rdata",  bus.if_rdata,      32'h0);
    check_value("rst dm_rdata",  bus.dm_rdata,      32'h0);
    check_value("rst if_valid",  32'(bus.if_valid), 32'd0);
    check_value("rst dm_valid",  32'(bus.dm_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Stray acknowledge while idle
    stray_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_value("stray if_valid", 32'(bus.if_valid), 32'd0);
      check_value("stray dm_valid", 32'(bus.dm_valid), 32'd0);
      check_value("stray mem_req",  32'(bus.mem_req),  32'd0);
    end
    stray_ack = 1'b0;
    check_value("stray if_rdata", bus.if_rdata, 32'h0);

    // Fetch only, minimum latency
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0040_0000;
    @(posedge clk); #1;
    check_value("fetch mem_req",  32'(bus.mem_req), 32'd1);
    check_value("fetch mem_addr", bus.mem_addr,     32'h0040_0000);
    check_value("fetch mem_we",   32'(bus.mem_we),  32'd0);
    check_value("fetch stall busy", 32'(bus.stall), 32'd1);
    wait_valid("fetch", 1'b1, cyc);
    check_value("fetch latency",  32'(cyc),         32'd1);
    check_value("fetch if_rdata", bus.if_rdata,     32'h2008_0005);
    check_value("fetch stall done", 32'(bus.stall), 32'd0);
    check_value("fetch idle bus", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    bus.if_req = 1'b0;
    @(posedge clk); #1;
    check_value("fetch pulse width", 32'(bus.if_valid), 32'd0);

    // Contention: data first, then fetch after one idle cycle
    @(negedge clk);
    grant_log.delete();
    bus.if_req  = 1'b1;
    bus.dm_load = 1'b1;
    bus.dm_addr = 32'h1001_0000;
    wait_valid("contention dm", 1'b0, cyc);
    check_value("contention dm_rdata", bus.dm_rdata,      32'hEFFE_FFFF);
    check_value("contention if_valid", 32'(bus.if_valid), 32'd0);
    check_value("contention stall",    32'(bus.stall),    32'd1);
    @(negedge clk);
    bus.dm_load = 1'b0;
    @(posedge clk); #1;
    check_value("contention if grant", 32'(bus.mem_req), 32'd1);
    check_value("contention if addr",  bus.mem_addr,     32'h0040_0000);
    wait_valid("contention if", 1'b1, cyc);
    check_value("contention grants", 32'(grant_log.size()), 32'd2);
    @(negedge clk);
    bus.if_req = 1'b0;

    // Starvation window with IF_STARVE_MAX = 2
    @(negedge clk);
    grant_log.delete();
    bus.if_req  = 1'b1;
    bus.dm_load = 1'b1;
    bus.dm_addr = 32'h1001_0008;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (grant_log.size() >= 6) break;
    end
    // Drop both requests mid-fetch; the fetch must still complete
    bus.if_req  = 1'b0;
    bus.dm_load = 1'b0;
    wait_valid("starve drop", 1'b1, cyc);
    check_value("starve if_rdata", bus.if_rdata, 32'h2008_0005);
    check_value("starve dm_rdata", bus.dm_rdata, 32'hEFFE_FFF7);
    for (int i = 0; i < 6; i++)
      check_value($sformatf("starve grant %0d", i), grant_log[i][31:0], exp_order[i]);

    // Store with a 3-cycle memory
    @(negedge clk);
    ack_delay    = 3;
    bus.dm_store = 1'b1;
    bus.dm_addr  = 32'h1001_0004;
    bus.dm_wdata = 32'hDEAD_BEEF;
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.dm_valid) break;
      if (bus.mem_req) begin
        busy++;
        check_value("store addr",  bus.mem_addr,     32'h1001_0004);
        check_value("store wdata", bus.mem_wdata,    32'hDEAD_BEEF);
        check_value("store we",    32'(bus.mem_we),  32'd1);
      end
    end
    check_value("store busy cycles", 32'(busy),         32'd3);
    check_value("store dm_valid",    32'(bus.dm_valid), 32'd1);
    check_value("store dm_rdata",    bus.dm_rdata,      32'hEFFE_FFF7);
    @(negedge clk);
    bus.dm_store = 1'b0;
    @(posedge clk); #1;
    check_value("store pulse width", 32'(bus.dm_valid), 32'd0);

    // Load and store together act as a store
    @(negedge clk);
    ack_delay    = 1;
    bus.dm_load  = 1'b1;
    bus.dm_store = 1'b1;
    bus.dm_addr  = 32'h1001_0020;
    bus.dm_wdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    check_value("both we",    32'(bus.mem_we), 32'd1);
    check_value("both wdata", bus.mem_wdata,   32'h0BAD_F00D);
    wait_valid("both", 1'b0, cyc);
    check_value("both dm_rdata", bus.dm_rdata, 32'hEFFE_FFF7);
    @(negedge clk);
    bus.dm_load  = 1'b0;
    bus.dm_store = 1'b0;

    // Reset in the middle of a data access
    @(negedge clk);
    ack_delay   = 5;
    bus.dm_load = 1'b1;
    bus.dm_addr = 32'h1001_0010;
    @(posedge clk); #1;
    check_value("midrst granted", 32'(bus.mem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_value("midrst mem_req",  32'(bus.mem_req), 32'd0);
    check_value("midrst mem_addr", bus.mem_addr,     32'h0);
    check_value("midrst if_rdata", bus.if_rdata,     32'h0);
    check_value("midrst dm_rdata", bus.dm_rdata,     32'h0);
    @(negedge clk);
    bus.dm_load = 1'b0;
    @(negedge clk);
    reset   = 1'b1;
    n_valid = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.dm_valid) n_valid++;
    end
    check_value("midrst no dm_valid", 32'(n_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
